// File: rtl/pipe_ctrl.sv
`timescale 1ns/1ps
// pipe_ctrl -- pipeline control unit for the five-stage RISC-V core.
//
// Purpose:
//   Arbitrates the single shared memory port between instruction fetch (IF)
//   and the MEM stage, generates the per-stage hold vector (stall_sign) and
//   bubble vector (flush_sign), and tracks a fetch left in flight across a
//   taken jump so the stale instruction is dropped (if_discard).
//
// Ports:
//   clk            in   core clock
//   rst            in   asynchronous active-low reset
//   if_mem_req     in   IF fetch request, held until its port_done
//   mem_mem_req    in   MEM load/store request, held until its port_done
//   port_done      in   one-cycle completion pulse from the memory port
//   id_ld_hazard   in   load-use hazard detected in ID
//   ex_jump        in   taken branch/jump resolved in EX this cycle
//   port_start     out  one-cycle pulse launching a memory transaction
//   port_sel       out  transaction owner: 0 = IF, 1 = MEM (valid while busy)
//   stall_sign     out  hold bits: [0] pc [1] IF [2] if_id [3] id_ex
//                       [4] ex_mem [5] mem_wb
//   flush_sign     out  same bit map, 1 loads a NOP into that register
//   if_discard     out  qualifies port_done: drop the returned instruction
//   perf_stall_cnt out  cycles with any stall (PIPE_CTRL_PERF_EN only)
//   perf_flush_cnt out  cycles with any flush (PIPE_CTRL_PERF_EN only)
//
// Handshake: a requester raises its *_mem_req and holds it until the port
// returns port_done while that requester owns the port. port_start/port_sel
// follow a grant by one cycle; port_done is only honoured in a busy state.
//
// Optional feature macro: PIPE_CTRL_PERF_EN (performance counters).
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_mem_req,
    input  logic        mem_mem_req,
    input  logic        port_done,
    input  logic        id_ld_hazard,
    input  logic        ex_jump,
    output logic        port_start,
    output logic        port_sel,
    output logic [5:0]  stall_sign,
    output logic [5:0]  flush_sign,
    output logic        if_discard
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       port_start_q, port_start_d;
    logic       port_sel_q, port_sel_d;
    logic       discard_pending_q, discard_pending_d;

    logic       done_if, done_mem;
    logic       mem_wait, if_wait;
    logic       flush_eff;
    logic [5:0] stall_raw;

    always_comb begin
        done_if  = port_done && (state_q == IF_BUSY);
        done_mem = port_done && (state_q == MEM_BUSY);

        // A request is still waiting unless its own completion arrives now.
        mem_wait = mem_mem_req && !done_mem;
        if_wait  = if_mem_req && !done_if;

        // A jump during a MEM wait is deferred: EX is held and re-presents it.
        flush_eff = ex_jump && !mem_wait;

        stall_raw = 6'b000000;
        if (mem_wait)     stall_raw = stall_raw | 6'b011111;
        if (id_ld_hazard) stall_raw = stall_raw | 6'b000111;
        if (if_wait)      stall_raw = stall_raw | 6'b000011;

        // Grant evaluation in IDLE or on the completion cycle of a busy state.
        // The requester that just completed is masked via mem_wait/if_wait,
        // which gives back-to-back service to the other side.
        state_d      = state_q;
        port_start_d = 1'b0;
        if ((state_q == IDLE) || port_done) begin
            if (mem_wait) begin
                state_d      = MEM_BUSY;
                port_start_d = 1'b1;
            end else if (if_wait) begin
                state_d      = IF_BUSY;
                port_start_d = 1'b1;
            end else begin
                state_d      = IDLE;
            end
        end
        port_sel_d = (state_d == MEM_BUSY);

        // Remember a flush that overtook an in-flight fetch; the completion
        // consumes it. A flush on the completion cycle is handled directly.
        discard_pending_d = discard_pending_q;
        if (done_if) begin
            discard_pending_d = 1'b0;
        end else if (flush_eff && (state_q == IF_BUSY)) begin
            discard_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= IDLE;
            port_start_q      <= 1'b0;
            port_sel_q        <= 1'b0;
            discard_pending_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            port_start_q      <= port_start_d;
            port_sel_q        <= port_sel_d;
            discard_pending_q <= discard_pending_d;
        end
    end

    assign port_start = port_start_q;
    assign port_sel   = port_sel_q;

    // Control vectors are forced quiet while reset is held.
    assign stall_sign = rst ? stall_raw : 6'b000000;
    assign flush_sign = (rst && flush_eff) ? 6'b001100 : 6'b000000;
    assign if_discard = rst && done_if && (discard_pending_q || flush_eff);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        perf_flush_cnt_d = perf_flush_cnt_q;
        if (stall_sign != 6'b000000) perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        if (flush_sign != 6'b000000) perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt_q <= 32'd0;
            perf_flush_cnt_q <= 32'd0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage RISC-V core. It arbitrates the single shared memory port between instruction fetch (IF) and the MEM stage. It also generates the per-stage `stall_sign` hold vector and the `flush_sign` bubble vector consumed by pc_reg and the inter-stage registers (if_id, id_ex, ex_mem, mem_wb). It tracks fetches left in flight across a taken jump, so that the stale instruction is discarded.

## Interface
- No parameters; `StallBus` is 6 bits (`[5:0]`).
- `clk  in  1` — core clock.
- `rst  in  1` — asynchronous, active-low reset.
- `if_mem_req  in  1` — IF requests an instruction fetch; held until its `port_done`.
- `mem_mem_req  in  1` — MEM stage requests a load/store; held until its `port_done`.
- `port_done  in  1` — one-cycle completion pulse from the memory port.
- `id_ld_hazard  in  1` — ID detects a load-use hazard against the instruction in EX.
- `ex_jump  in  1` — EX resolved a taken branch or jump this cycle.
- `port_start  out  1` — one-cycle pulse launching a memory transaction.
- `port_sel  out  1` — transaction owner: 0 = IF, 1 = MEM; valid while busy.
- `stall_sign  out  6` — hold bits: [0] pc, [1] IF, [2] if_id, [3] id_ex, [4] ex_mem, [5] mem_wb.
- `flush_sign  out  6` — same bit map; a 1 loads a NOP into that register.
- `if_discard  out  1` — qualifies `port_done`: the returned instruction must be dropped.
- `perf_stall_cnt  out  32`, `perf_flush_cnt  out  32` — present only with `PIPE_CTRL_PERF_EN`.

## Operation
- Arbiter FSM states: IDLE, IF_BUSY, MEM_BUSY.
- Grant evaluation takes place in IDLE, or in a busy state on the `port_done` cycle, which allows back-to-back grants.
  - The requester that just completed is masked for that cycle.
  - MEM wins over IF.
  - A granted request moves the FSM to MEM_BUSY or IF_BUSY; with no request, the FSM returns to IDLE.
- `port_sel` is 1 exactly in MEM_BUSY. `port_start` is high for the first cycle of each busy state only.
- `port_done` is ignored in IDLE. This covers stale completions after reset.
- `stall_sign` is the bitwise OR of three patterns:
  - MEM wait (`mem_mem_req` and not completing this cycle): 6'b011111.
  - Load-use (`id_ld_hazard`): 6'b000111.
  - IF wait (`if_mem_req` and not completing this cycle): 6'b000011.
- `flush_sign` = 6'b001100 (if_id, id_ex) when `ex_jump` is 1 and no MEM wait is active; otherwise 0.
  - During a MEM wait the jump is deferred. EX is held, so `ex_jump` is re-presented when the wait ends.
  - When `ex_jump` and `id_ld_hazard` coincide, the flush wins for bit 3: `id_ex` loads a NOP.
- Discard tracking with register `discard_pending`:
  - An effective flush while in IF_BUSY sets it, unless `port_done` occurs in the same cycle.
  - `if_discard` = `port_done` & IF_BUSY & (`discard_pending` | effective flush this cycle).
  - `port_done` in IF_BUSY clears `discard_pending`.
- Reset (asynchronous, any state, mid-transaction included):
  - FSM goes to IDLE.
  - `port_start`, `discard_pending`, and the counters go to 0.
  - While `rst` is low, `stall_sign`, `flush_sign` and `if_discard` are forced to 0.

## Timing
- Grant decided in cycle N. `port_start` and `port_sel` are valid in N+1. The earliest legal `port_done` is N+2.
- Stall is asserted combinationally from the first cycle a request is pending. It drops in the same cycle as the owner's `port_done`.
- After `port_done` in cycle M, a queued request sees `port_start` in M+1.
- `flush_sign` and `if_discard` are combinational, with zero latency from `ex_jump` and `port_done`.
- Perf counters update on the clock edge; they wrap modulo 2^32.

## Configuration
- `PIPE_CTRL_PERF_EN`
  - Defined: adds `perf_stall_cnt`, which increments on each cycle with `stall_sign != 0`, and `perf_flush_cnt`, which increments on each cycle with `flush_sign != 0`.
  - Undefined: both ports and their registers are absent; all other behaviour is identical.

## Test plan
- **Simultaneous requests:** in IDLE, `if_mem_req`=`mem_mem_req`=1 at cycle 0 → `port_start`=1 with `port_sel`=1 at cycle 1. `stall_sign`=6'b011111 until `port_done` at cycle 3. IF is granted at cycle 4 with `port_sel`=0 and `stall_sign`=6'b000011.
- **Load-use with pending fetch:** `id_ld_hazard`=1 with an IF fetch pending → `stall_sign`=6'b000111 and `flush_sign`=0.
- **Jump during in-flight fetch:** `ex_jump` pulse at cycle 5 while IF_BUSY, `port_done` at cycle 7 → `flush_sign`=6'b001100 at cycle 5, `if_discard`=1 at cycle 7 only. A subsequent fetch completes with `if_discard`=0.
- **Jump coincident with IF completion:** `ex_jump` and IF `port_done` in the same cycle → `if_discard`=1 that cycle and `discard_pending` stays 0.
- **Jump during MEM wait:** `ex_jump`=1 while MEM_BUSY → `flush_sign`=0 until the MEM `port_done` cycle, then 6'b001100.
- **Mid-transaction reset and counters:** `rst` low for 1 cycle mid MEM_BUSY, then a stray `port_done` → FSM stays IDLE and `port_start` stays 0. With `PIPE_CTRL_PERF_EN`, 10 stalled cycles give `perf_stall_cnt`=10.
